// File: rtl/data_memory_responder.sv
// data_memory_responder: request/response data-memory slave with a fixed,
// parameterised access latency and big-endian byte-addressed storage.
// One transaction in flight: IDLE -> WAIT (WAIT_STATES cycles) -> ACCESS -> RESP.
// Optional build macro: DMEM_HALF_STORE_EN enables 16-bit stores
// (req_size 2/3 on a store writes req_wdata[15:0] to addr, addr+1).
//
// state  | meaning
// IDLE   | ready for a request (after the first edge out of reset)
// WAIT   | latency padding, counter runs down to 0
// ACCESS | legality check, storage read/write, response registered
// RESP   | response held until rsp_ready

module data_memory_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          AW        = (DEPTH_BYTES > 2) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [3:0]  CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [32:0] DEPTH_LIM = 33'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_live;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_error;
    logic [7:0]  r_mem [DEPTH_BYTES];

    logic        w_accept;
    logic        w_half_store;
    logic        w_half;
    logic [32:0] w_nbytes;
    logic        w_align_ok;
    logic        w_range_ok;
    logic        w_size_ok;
    logic        w_legal;
    logic [AW-1:0] w_i0;
    logic [AW-1:0] w_i1;
    logic [AW-1:0] w_i2;
    logic [AW-1:0] w_i3;
    logic [7:0]  w_b0;
    logic [7:0]  w_b1;
    logic [7:0]  w_b2;
    logic [7:0]  w_b3;
    logic [31:0] w_load_data;

    assign w_accept = req_ready && req_valid;

`ifdef DMEM_HALF_STORE_EN
    assign w_half_store = r_write && r_size[1];
`else
    assign w_half_store = 1'b0;
`endif

    // Legality check on the latched request; range test is 33-bit so no wrap.
    always_comb begin
        w_half     = r_write ? w_half_store : r_size[1];
        w_nbytes   = w_half ? 33'd2 : 33'd4;
        w_align_ok = w_half ? ~r_addr[0] : (r_addr[1:0] == 2'b00);
        w_range_ok = ({1'b0, r_addr} + w_nbytes) <= DEPTH_LIM;
        w_size_ok  = r_write || (r_size != 2'd0);
        w_legal    = w_align_ok && w_range_ok && w_size_ok;
    end

    assign w_i0 = r_addr[AW-1:0];
    assign w_i1 = r_addr[AW-1:0] + AW'(1);
    assign w_i2 = r_addr[AW-1:0] + AW'(2);
    assign w_i3 = r_addr[AW-1:0] + AW'(3);
    assign w_b0 = r_mem[w_i0];
    assign w_b1 = r_mem[w_i1];
    assign w_b2 = r_mem[w_i2];
    assign w_b3 = r_mem[w_i3];

    // Load result assembly: byte at addr is most significant.
    always_comb begin
        w_load_data = {w_b0, w_b1, w_b2, w_b3};
        if (w_half) begin
            if (r_size == 2'd2) begin
                w_load_data = {{16{w_b0[7]}}, w_b0, w_b1};
            end else begin
                w_load_data = {16'h0000, w_b0, w_b1};
            end
        end
    end

    // State register plus the out-of-reset flag that gates req_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = r_live;
                if (w_accept) begin
                    w_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request capture, wait counter and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_ACCESS) begin
                r_error <= ~w_legal;
                r_rdata <= (w_legal && !r_write) ? w_load_data : 32'h0;
            end
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && r_write && w_legal) begin
            if (w_half) begin
                r_mem[w_i0] <= r_wdata[15:8];
                r_mem[w_i1] <= r_wdata[7:0];
            end else begin
                r_mem[w_i0] <= r_wdata[31:24];
                r_mem[w_i1] <= r_wdata[23:16];
                r_mem[w_i2] <= r_wdata[15:8];
                r_mem[w_i3] <= r_wdata[7:0];
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

endmodule

// File: tb/tb_data_memory_responder.sv
// Testbench for data_memory_responder: directed scenarios plus randomized
// traffic checked against a byte-array reference model.

module tb_data_memory_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_mem [DEPTH];

    data_memory_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: apply the access rules to a byte array.
    function automatic void model_op(input logic wr, input logic [1:0] sz,
                                     input logic [31:0] ad, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
        logic half;
        longint unsigned nb;
        logic [15:0] hv;
`ifdef DMEM_HALF_STORE_EN
        half = (sz >= 2'd2);
`else
        half = wr ? 1'b0 : (sz >= 2'd2);
`endif
        nb = half ? 2 : 4;
        er = 1'b0;
        rd = 32'h0;
        if (!wr && sz == 2'd0) er = 1'b1;
        if ((longint'(ad) % nb) != 0) er = 1'b1;
        if (longint'(ad) + nb > longint'(DEPTH)) er = 1'b1;
        if (!er) begin
            if (wr) begin
                if (half) begin
                    m_mem[ad]   = wd[15:8];
                    m_mem[ad+1] = wd[7:0];
                end else begin
                    m_mem[ad]   = wd[31:24];
                    m_mem[ad+1] = wd[23:16];
                    m_mem[ad+2] = wd[15:8];
                    m_mem[ad+3] = wd[7:0];
                end
            end else if (half) begin
                hv = {m_mem[ad], m_mem[ad+1]};
                rd = (sz == 2'd2) ? {{16{hv[15]}}, hv} : {16'h0, hv};
            end else begin
                rd = {m_mem[ad], m_mem[ad+1], m_mem[ad+2], m_mem[ad+3]};
            end
        end
    endfunction

    // One full transaction; inputs move #1 after edges, outputs sampled there.
    task automatic do_txn(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] got_rd, output logic got_er);
        logic [31:0] er_d;
        logic        er_e;
        logic [31:0] r0;
        logic        e0;
        int n;
        model_op(wr, sz, ad, wd, er_d, er_e);
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = ad;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_size  = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, WS + 1);
        chk("rdata", rsp_rdata, er_d);
        chk("error", {31'b0, rsp_error}, {31'b0, er_e});
        r0 = rsp_rdata;
        e0 = rsp_error;
        got_rd = rsp_rdata;
        got_er = rsp_error;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, r0);
            chk("hold_error", {31'b0, rsp_error}, {31'b0, e0});
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
        chk("idle_keep", rsp_rdata, r0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          sel;

        #2 reset = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_error", {31'b0, rsp_error}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_ready_low", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rel_ready_high", {31'b0, req_ready}, 32'd1);

        // Known contents for every byte that later loads may touch.
        for (int a = 0; a < 64; a += 4) do_txn(1'b1, 2'd1, 32'(a), $urandom, 0, rd, er);
        for (int a = 1008; a < 1024; a += 4) do_txn(1'b1, 2'd1, 32'(a), $urandom, 0, rd, er);

        do_txn(1'b1, 2'd1, 32'h8, 32'h11223344, 0, rd, er);
        chk("st8_err", {31'b0, er}, 32'd0);
        do_txn(1'b0, 2'd1, 32'h8, 32'h0, 0, rd, er);
        chk("ld8", rd, 32'h11223344);

        do_txn(1'b1, 2'd1, 32'h10, 32'h0000F0A5, 0, rd, er);
        do_txn(1'b0, 2'd2, 32'h12, 32'h0, 0, rd, er);
        chk("ld_sh", rd, 32'hFFFFF0A5);
        do_txn(1'b0, 2'd3, 32'h12, 32'h0, 0, rd, er);
        chk("ld_uh", rd, 32'h0000F0A5);

        do_txn(1'b0, 2'd1, 32'h6, 32'h0, 1, rd, er);
        chk("mis_ld_err", {31'b0, er}, 32'd1);
        chk("mis_ld_data", rd, 32'h0);
        do_txn(1'b1, 2'd1, 32'h3FC, 32'hCAFEF00D, 0, rd, er);
        do_txn(1'b1, 2'd1, 32'h3FE, 32'hDEADBEEF, 0, rd, er);
        chk("oor_st_err", {31'b0, er}, 32'd1);
        do_txn(1'b0, 2'd1, 32'h3FC, 32'h0, 0, rd, er);
        chk("ld_3fc", rd, 32'hCAFEF00D);
        do_txn(1'b0, 2'd3, 32'h3FE, 32'h0, 0, rd, er);
        chk("top_half", rd, 32'h0000F00D);
        do_txn(1'b0, 2'd1, 32'h400, 32'h0, 0, rd, er);
        chk("ld_400_err", {31'b0, er}, 32'd1);
        do_txn(1'b0, 2'd1, 32'hFFFFFFFC, 32'h0, 0, rd, er);
        chk("wrap_err", {31'b0, er}, 32'd1);
        do_txn(1'b0, 2'd0, 32'h8, 32'h0, 0, rd, er);
        chk("size0_err", {31'b0, er}, 32'd1);
        do_txn(1'b0, 2'd1, 32'h8, 32'h0, 5, rd, er);

        // Reset during WAIT of a store drops it.
        do_txn(1'b1, 2'd1, 32'h20, 32'h5A5A5A5A, 0, rd, er);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd1;
        req_addr  = 32'h20;
        req_wdata = 32'h99887766;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        do_txn(1'b0, 2'd1, 32'h20, 32'h0, 0, rd, er);
        chk("ld20_kept", rd, 32'h5A5A5A5A);

`ifdef DMEM_HALF_STORE_EN
        do_txn(1'b1, 2'd1, 32'h0, 32'hAABBCCDD, 0, rd, er);
        do_txn(1'b1, 2'd2, 32'h2, 32'h00001234, 0, rd, er);
        do_txn(1'b0, 2'd1, 32'h0, 32'h0, 0, rd, er);
        chk("half_store", rd, 32'hAABB1234);
`endif

        for (int t = 0; t < 250; t++) begin
            sel = $urandom_range(0, 99);
            wr  = 1'($urandom);
            sz  = 2'($urandom);
            if (sel < 70)      ad = 32'($urandom_range(0, 63));
            else if (sel < 88) ad = 32'($urandom_range(1008, 1031));
            else               ad = $urandom;
            do_txn(wr, sz, ad, $urandom, $urandom_range(0, 3), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
